// File: rtl/keypad_pkg.sv
// Shared constants, event type and scan helper for the keypad event front end.
package keypad_pkg;

   localparam int unsigned MAX_KEYS  = 256;
   localparam int unsigned MAX_IDX_W = 8;

   localparam logic EVT_PRESS   = 1'b0;
   localparam logic EVT_RELEASE = 1'b1;

   typedef struct packed {
      logic                 is_release;
      logic [MAX_IDX_W-1:0] index;
   } key_evt_t;

   // Index of the lowest set bit; 0 when the vector is all zero.
   function automatic int unsigned lowest_set(input logic [MAX_KEYS-1:0] v);
      int unsigned idx;
      idx = 0;
      for (int i = MAX_KEYS - 1; i >= 0; i--) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_events_fifo.sv
// Synchronous show-ahead FIFO for keypad events, with flush taking priority.
module evt_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4,
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PtrW:0]    count
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (PtrW + 1)'(Depth));
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   // A full queue still accepts a write when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
      end
   end

endmodule

// File: rtl/keypad_events.sv
// Keypad front end: synchronise, debounce, capture press/release edges and queue
// them as indexed events behind a valid/ready pop port.
module keypad_events
   import keypad_pkg::*;
#(
   parameter int unsigned NUM_KEYS   = 16,
   parameter int unsigned DEBOUNCE   = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned IDX_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                sample_tick,
   input  logic [NUM_KEYS-1:0] keypad_matrix,
   input  logic                report_press,
   input  logic                report_release,
   input  logic                flush,
   output logic [NUM_KEYS-1:0] key_state,
   output logic                any_down,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [IDX_W-1:0]    evt_index,
   output logic                evt_release,
   output logic                overflow
);

   localparam int unsigned      CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
   localparam int unsigned      FCNT_W   = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_KEYS-1:0] sync_q, raw_s;
   logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
   logic [NUM_KEYS-1:0] flip, state_d;
   logic [NUM_KEYS-1:0] pend_p_q, pend_r_q, pend_any;
   logic [NUM_KEYS-1:0] set_p, set_r, clr_p, clr_r, merge;
   logic [IDX_W-1:0]    sel_idx;
   logic                sel_rel;
   logic                push, pop;
   logic                fifo_full, fifo_empty;
   logic [FCNT_W-1:0]   fifo_count;
   logic [IDX_W:0]      fifo_rdata;

   always_comb begin
      flip = '0;
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
         flip[k] = sample_tick && (raw_s[k] != key_state[k]) && (cnt_q[k] == CNT_LAST);
      end
   end

   assign state_d  = key_state ^ flip;
   assign set_p    = flip & ~key_state & {NUM_KEYS{report_press}};
   assign set_r    = flip & key_state & {NUM_KEYS{report_release}};
   assign pend_any = pend_p_q | pend_r_q;
   assign sel_idx  = IDX_W'(lowest_set(MAX_KEYS'(pend_any)));

   assign evt_valid = !fifo_empty;
   assign pop       = evt_valid && evt_ready;
   assign push      = (|pend_any) && (!fifo_full || pop);

   // With both edges pending, the current level tells which one happened first.
   always_comb begin
      clr_p = '0;
      clr_r = '0;
      if (pend_p_q[sel_idx] && pend_r_q[sel_idx]) sel_rel = key_state[sel_idx];
      else                                        sel_rel = pend_r_q[sel_idx];
      if (push) begin
         if (sel_rel) clr_r[sel_idx] = 1'b1;
         else         clr_p[sel_idx] = 1'b1;
      end
   end

   assign merge = (set_p & pend_p_q & ~clr_p) | (set_r & pend_r_q & ~clr_r);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= '0;
         raw_s     <= '0;
         key_state <= '0;
         any_down  <= 1'b0;
         pend_p_q  <= '0;
         pend_r_q  <= '0;
         overflow  <= 1'b0;
         for (int k = 0; k < int'(NUM_KEYS); k++) cnt_q[k] <= '0;
      end else begin
         sync_q    <= keypad_matrix;
         raw_s     <= sync_q;
         key_state <= state_d;
         any_down  <= |state_d;
         if (sample_tick) begin
            for (int k = 0; k < int'(NUM_KEYS); k++) begin
               if (raw_s[k] == key_state[k] || cnt_q[k] == CNT_LAST) cnt_q[k] <= '0;
               else                                                  cnt_q[k] <= cnt_q[k] + 1'b1;
            end
         end
         if (flush) begin
            pend_p_q <= '0;
            pend_r_q <= '0;
            overflow <= 1'b0;
         end else begin
            pend_p_q <= (pend_p_q & ~clr_p) | set_p;
            pend_r_q <= (pend_r_q & ~clr_r) | set_r;
            overflow <= overflow | (|merge);
         end
      end
   end

   evt_fifo #(
      .Width(IDX_W + 1),
      .Depth(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .push   (push),
      .pop    (pop),
      .flush  (flush),
      .wdata  ({sel_rel, sel_idx}),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   assign evt_release = fifo_rdata[IDX_W];
   assign evt_index   = fifo_rdata[IDX_W-1:0];

   count_bound: assert property (@(posedge clk) disable iff (!reset_n)
      (fifo_count <= FCNT_W'(FIFO_DEPTH)) && (fifo_empty == (fifo_count == '0)));

endmodule

// File: tb/tb_keypad_events.sv
// Scoreboard bench for keypad_events: a per-key tick model predicts events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_keypad_events;
   import keypad_pkg::*;

   localparam int unsigned NK = 16;
   localparam int unsigned DB = 2;
   localparam int unsigned FD = 4;

   logic          clk = 1'b0;
   logic          reset_n, sample_tick, report_press, report_release, flush, evt_ready;
   logic [NK-1:0] keypad_matrix, key_state;
   logic          any_down, evt_valid, evt_release, overflow;
   logic [3:0]    evt_index;

   int tests = 0;
   int fails = 0;

   key_evt_t      exp_q[$];
   logic [NK-1:0] m_raw, m_state;
   int            m_cnt[NK];

   always #5 clk = ~clk;

   keypad_events #(
      .NUM_KEYS  (NK),
      .DEBOUNCE  (DB),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .sample_tick   (sample_tick),
      .keypad_matrix (keypad_matrix),
      .report_press  (report_press),
      .report_release(report_release),
      .flush         (flush),
      .key_state     (key_state),
      .any_down      (any_down),
      .evt_valid     (evt_valid),
      .evt_ready     (evt_ready),
      .evt_index     (evt_index),
      .evt_release   (evt_release),
      .overflow      (overflow)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      key_evt_t e;
      if (reset_n && evt_valid && evt_ready && !flush) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got index %0d release %0b expected none",
                     evt_index, evt_release);
         end else begin
            e = exp_q.pop_front();
            check("evt_index", 32'(evt_index), 32'(e.index));
            check("evt_release", 32'(evt_release), 32'(e.is_release));
         end
      end
   end

   // A key changes once it has seen DB differing ticks in a row.
   task automatic model_tick();
      key_evt_t e;
      for (int k = 0; k < int'(NK); k++) begin
         if (m_raw[k] == m_state[k]) begin
            m_cnt[k] = 0;
         end else begin
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == int'(DB)) begin
               m_cnt[k]   = 0;
               m_state[k] = m_raw[k];
               e.index    = MAX_IDX_W'(k);
               e.is_release = !m_state[k];
               if ((m_state[k] && report_press) || (!m_state[k] && report_release))
                  exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
      model_tick();
      check("key_state", 32'(key_state), 32'(m_state));
      check("any_down", 32'(any_down), 32'(|m_state));
   endtask

   task automatic set_keys(input logic [NK-1:0] v);
      keypad_matrix = v;
      m_raw         = v;
      repeat (3) cyc();
   endtask

   task automatic drain();
      int waited;
      waited    = 0;
      evt_ready = 1'b1;
      while (exp_q.size() != 0 && waited < 200) begin
         cyc();
         waited++;
      end
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d events outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) cyc();
      check("idle_valid", 32'(evt_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NK-1:0] v;
      int            n, nt;

      reset_n        = 1'b0;
      sample_tick    = 1'b0;
      keypad_matrix  = '0;
      report_press   = 1'b1;
      report_release = 1'b1;
      flush          = 1'b0;
      evt_ready      = 1'b0;
      m_raw          = '0;
      m_state        = '0;
      for (int k = 0; k < int'(NK); k++) m_cnt[k] = 0;
      repeat (3) cyc();
      check("rst_key_state", 32'(key_state), 32'd0);
      check("rst_any_down", 32'(any_down), 32'd0);
      check("rst_evt_valid", 32'(evt_valid), 32'd0);
      check("rst_evt_index", 32'(evt_index), 32'd0);
      check("rst_evt_release", 32'(evt_release), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      reset_n = 1'b1;
      cyc();

      // Press and release of key 5.
      evt_ready = 1'b1;
      set_keys(NK'(1) << 5);
      repeat (3) tick();
      set_keys('0);
      repeat (3) tick();
      drain();
      check("ovf_after_key5", 32'(overflow), 32'd0);

      // Single-tick glitch on key 3.
      set_keys(NK'(1) << 3);
      tick();
      set_keys('0);
      repeat (2) tick();
      drain();

      // Keys 9 and 2 flip together: 2 then 9 on consecutive cycles.
      set_keys((NK'(1) << 9) | (NK'(1) << 2));
      repeat (2) tick();
      cyc();
      @(negedge clk);
      check("pair_valid0", 32'(evt_valid), 32'd1);
      check("pair_index0", 32'(evt_index), 32'd2);
      @(negedge clk);
      check("pair_valid1", 32'(evt_valid), 32'd1);
      check("pair_index1", 32'(evt_index), 32'd9);
      cyc();
      set_keys('0);
      repeat (2) tick();
      drain();

      // Six presses against a stalled consumer: backpressure, not loss.
      evt_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_keys(m_raw | (NK'(1) << i));
         repeat (2) tick();
      end
      repeat (4) cyc();
      check("bp_valid", 32'(evt_valid), 32'd1);
      check("bp_head", 32'(evt_index), 32'd0);
      check("bp_overflow", 32'(overflow), 32'd0);
      drain();
      set_keys('0);
      repeat (2) tick();
      drain();

      // Release-only reporting on key 10.
      report_press = 1'b0;
      set_keys(NK'(1) << 10);
      repeat (2) tick();
      set_keys('0);
      repeat (2) tick();
      drain();
      report_press = 1'b1;

      // Fill the queue, merge a repeated press on key 7, then flush.
      evt_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_keys(m_raw | (NK'(1) << i));
         repeat (2) tick();
      end
      set_keys(m_raw | (NK'(1) << 7));
      repeat (2) tick();
      check("ovf_before_merge", 32'(overflow), 32'd0);
      set_keys(m_raw & ~(NK'(1) << 7));
      repeat (2) tick();
      set_keys(m_raw | (NK'(1) << 7));
      repeat (2) tick();
      check("ovf_merge", 32'(overflow), 32'd1);
      flush     = 1'b1;
      evt_ready = 1'b1;
      cyc();
      flush = 1'b0;
      exp_q.delete();
      check("flush_valid", 32'(evt_valid), 32'd0);
      check("flush_overflow", 32'(overflow), 32'd0);
      check("flush_key_state", 32'(key_state), 32'(m_state));
      repeat (5) cyc();
      check("flush_pending_gone", 32'(evt_valid), 32'd0);
      set_keys('0);
      repeat (2) tick();
      drain();

      // Randomised key activity, modes and consumer stalls.
      for (int it = 0; it < 40; it++) begin
         v = m_raw;
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) v[$urandom_range(0, NK - 1)] ^= 1'b1;
         report_press   = ($urandom_range(0, 3) != 0);
         report_release = ($urandom_range(0, 3) != 0);
         set_keys(v);
         nt = $urandom_range(1, 3);
         for (int t = 0; t < nt; t++) begin
            tick();
            for (int c = 0; c < 4; c++) begin
               evt_ready = 1'($urandom_range(0, 1));
               cyc();
            end
            evt_ready = 1'b1;
            repeat (40) cyc();
         end
      end
      report_press   = 1'b1;
      report_release = 1'b1;
      set_keys('0);
      repeat (2) tick();
      drain();
      check("final_overflow", 32'(overflow), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/keypad_events.md
Name: keypad_events

Overview:
Parametrised keypad front end for the CPU. It synchronises and debounces a NUM_KEYS-wide raw key matrix on a sample strobe, and keeps a debounced level vector for the skip-if-key opcodes. Press and release edges become indexed events, queued in a small FIFO with a valid/ready pop port for the wait-for-key opcode. It replaces single-key, release-only, unbuffered detection with multi-key, mode-selectable, buffered detection.

Parameters:
NUM_KEYS, 16, number of keys; IDX_W = clog2(NUM_KEYS) derived, minimum 1
DEBOUNCE, 2, consecutive differing samples before a key changes state; legal 1..15
FIFO_DEPTH, 4, event queue entries; power of two, at least 2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sample_tick  in  1  one-cycle strobe, typically the vsync rising edge
keypad_matrix  in  NUM_KEYS  raw key lines, asynchronous, 1 = pressed
report_press  in  1  enable press events
report_release  in  1  enable release events
flush  in  1  discard queued and pending events, clear overflow
key_state  out  NUM_KEYS  debounced levels
any_down  out  1  OR of key_state
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer pops head when evt_valid is also high
evt_index  out  IDX_W  key index of head event
evt_release  out  1  0 = press, 1 = release
overflow  out  1  sticky: an event was merged or lost

Behaviour:
- Reset: key_state = 0, any_down = 0, evt_valid = 0, evt_index = 0, evt_release = 0, overflow = 0. All per-key counters, pending bits, FIFO pointers and the synchroniser are cleared.
- Synchroniser: two-flop synchroniser per key; the sampled value is raw_s.
- Debounce, evaluated only on clock edges where sample_tick = 1, per key k:
  - if raw_s[k] == key_state[k], the counter is set to 0;
  - otherwise the counter increments; when it reaches DEBOUNCE-1, key_state[k] toggles and the counter returns to 0.
  - With DEBOUNCE = 1 a key flips on the first differing tick.
  - Without sample_tick, key_state and the counters hold.
- Edge capture happens on the same edge as a flip:
  - a 0→1 flip sets pend_p[k] when report_press = 1;
  - a 1→0 flip sets pend_r[k] when report_release = 1.
  - If the bit being set is already set, overflow is set and the new event merges into the old one.
- Enqueue, one event per cycle:
  - The selected key is the lowest k with pend_p[k] or pend_r[k] set.
  - If both bits are set, order is chronological. When key_state[k] = 0, press is emitted first, then release. When key_state[k] = 1, release is emitted first, then press.
  - An enqueue clears the corresponding pending bit on the same edge.
  - Enqueue happens when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - When the FIFO is full, pending bits hold; this is backpressure, not loss.
- FIFO: show-ahead. evt_valid = not empty, and evt_index/evt_release always show the head entry.
  - A pop on evt_valid && evt_ready takes effect at the clock edge.
  - Simultaneous push and pop keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: with a clean input, the first differing edge plus DEBOUNCE-1 further ticks is the flip edge T. pend_* is set at T, the FIFO push happens at T+1, and evt_valid is high in the cycle after T+1. The raw input adds 2 cycles of synchroniser delay.
- flush is synchronous and has priority over push and pop in the same cycle. It:
  - clears the FIFO and all pend_p and pend_r bits;
  - clears overflow;
  - leaves key_state and the counters unchanged.
  - A flip on the same edge as flush is discarded.
- Mode inputs are sampled at flip time only. Changing them does not touch events that are already pending.
- any_down is registered together with key_state and adds no extra latency.

Decomposition:
- keypad_pkg holds:
  - the constants EVT_PRESS = 0 and EVT_RELEASE = 1;
  - the typedef key_evt_t as a struct {release, index};
  - a function for lowest-set-bit index.
- Natural sub-module: evt_fifo, a synchronous show-ahead FIFO parametrised by width and depth, with push/pop/flush, full/empty and count outputs.
- Debounce counters and the pending-bit scanner stay in keypad_events.

Test Plan:
- Defaults, hold key 5 high across 3 ticks, then release it across 3 ticks → key_state[5] rises after the 2nd tick. Expect the pair (index 5, press) then (index 5, release). overflow = 0.
- Key 3 glitches high for a single tick, then returns low → key_state unchanged and no event.
- Keys 9 and 2 flip on the same tick with evt_ready = 1 → events come out as index 2 then index 9 on consecutive cycles.
- evt_ready = 0, six press events across ticks with FIFO_DEPTH = 4 → 4 queued with the rest held pending, no overflow. Raising ready drains all 6 in order.
- report_press = 0, report_release = 1, tap key 0xA → exactly one event (index 10, release).
- Queue holds 3 events when flush is asserted together with evt_ready → evt_valid = 0 next cycle, overflow cleared, key_state retained.
